// File: rtl/par2ser_pkg.sv
// Shared types and frame sizing for the par2ser transmitter.
// Build option: PAR2SER_PARITY_EN appends an even-parity bit per frame.
package par2ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic int frame_len(input int w);
`ifdef PAR2SER_PARITY_EN
      return w + 1;
`else
      return w;
`endif
   endfunction

   // Holds 0..FRAME_LEN so the counter can run one past the last beat.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/par2ser_bitcnt.sv
// Frame bit counter; clear wins over advance on the same cycle.
// Build option: PAR2SER_PARITY_EN (via N) sets the frame length.
module par2ser_bitcnt #(
   parameter int N  = 8,
   parameter int CW = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_adv,
   output logic o_is_last
);

   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_adv) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_is_last = (r_cnt == LAST);

endmodule

// File: rtl/par2ser_tx.sv
// Word-to-bit serialiser with valid/ready on both sides, MSB/LSB first.
// Build option: PAR2SER_PARITY_EN adds a trailing even-parity bit.
module par2ser_tx
   import par2ser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             msb_first,
   output logic             ser_valid,
   input  logic             ser_ready,
   output logic             ser_out,
   output logic             ser_last,
   output logic             busy
);

   localparam int FL = frame_len(WIDTH);
   localparam int CW = cnt_width(FL);

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_shadow;
   logic             r_dir;
   logic             w_last;
   logic             w_take;
   logic             w_beat;
   logic             w_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // in_ready depends on ser_ready combinationally so frames chain with no bubble.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      w_take    = 1'b0;
      w_beat    = 1'b0;
      unique case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            w_take   = in_valid;
            if (in_valid) begin
               w_next = SHIFT;
            end
         end
         SHIFT: begin
            ser_valid = 1'b1;
            w_beat    = ser_ready;
            if (ser_ready && w_last) begin
               in_ready = 1'b1;
               w_take   = in_valid;
               if (!in_valid) begin
                  w_next = IDLE;
               end
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_shadow <= '0;
         r_dir    <= 1'b0;
      end else if (w_take) begin
         r_shadow <= in_data;
         r_dir    <= msb_first;
      end else if (w_beat) begin
         r_shadow <= r_dir ? (r_shadow << 1) : (r_shadow >> 1);
      end
   end

`ifdef PAR2SER_PARITY_EN
   logic r_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= 1'b0;
      end else if (w_take) begin
         r_par <= ^in_data;
      end
   end

   assign w_bit = w_last ? r_par
                : (r_dir ? r_shadow[WIDTH-1] : r_shadow[0]);
`else
   assign w_bit = r_dir ? r_shadow[WIDTH-1] : r_shadow[0];
`endif

   par2ser_bitcnt #(
      .N  (FL),
      .CW (CW)
   ) u_bitcnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clr     (w_take),
      .i_adv     (w_beat),
      .o_is_last (w_last)
   );

   assign ser_out  = ser_valid & w_bit;
   assign ser_last = ser_valid & w_last;
   assign busy     = (r_state == SHIFT);

endmodule

// File: tb/tb_par2ser_tx.sv
// Bench for par2ser_tx: vector table plus hand-built corner sequences.
// Build option: PAR2SER_PARITY_EN expects the trailing parity bit.
module tb_par2ser_tx;

   localparam int W = 8;
`ifdef PAR2SER_PARITY_EN
   localparam int FL  = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int FL  = W;
   localparam bit PAR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;
   logic         msb_first;
   logic         ser_valid;
   logic         ser_ready;
   logic         ser_out;
   logic         ser_last;
   logic         busy;

   always #5 clk = ~clk;

   par2ser_tx #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .msb_first (msb_first),
      .ser_valid (ser_valid),
      .ser_ready (ser_ready),
      .ser_out   (ser_out),
      .ser_last  (ser_last),
      .busy      (busy)
   );

   int n_chk  = 0;
   int n_pass = 0;
   int run    = 0;
   int max_run = 0;
   logic [1:0] q[$];

   typedef struct {
      logic [7:0] d;
      logic       msb;
      logic [7:0] seq;
      logic       par;
      logic       stall;
   } vec_t;

   vec_t tv[7];

   function automatic void check(string nm, logic [31:0] act,
                                 logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endfunction

   // seq lists the emitted data bits left to right (seq[7] goes first).
   function automatic void push_frame(logic [7:0] seq, logic p);
      for (int k = 0; k < W; k++)
         q.push_back({seq[7-k], (!PAR && k == W-1)});
      if (PAR) q.push_back({p, 1'b1});
   endfunction

   always @(negedge clk) begin
      logic [1:0] e;
      if (rst_n) begin
         if (ser_valid) begin
            run++;
            if (run > max_run) max_run = run;
         end else begin
            run = 0;
         end
         if (ser_valid && ser_ready) begin
            if (q.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_bit: got %0b%0b expected none",
                        ser_out, ser_last);
            end else begin
               e = q.pop_front();
               check("ser_bit_last", {ser_out, ser_last}, e);
            end
         end
      end else begin
         run = 0;
      end
   end

   task automatic send(input logic [7:0] d, input logic m,
                       input logic [7:0] seq, input logic p,
                       output logic lastseen);
      bit ok;
      ok       = 1'b0;
      lastseen = 1'b0;
      in_valid  = 1'b1;
      in_data   = d;
      msb_first = m;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok       = 1'b1;
            lastseen = ser_last;
            push_frame(seq, p);
         end
      end
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      in_data   = W'($urandom);
      msb_first = 1'($urandom);
      if (!ok) begin
         n_chk++;
         $display("FAIL send_timeout: got in_ready=0 expected 1");
      end
   endtask

   task automatic drain(input logic stall);
      for (int i = 0; i < 400 && q.size() != 0; i++) begin
         @(posedge clk);
         #1;
         ser_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ser_ready = 1'b1;
      if (q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d left expected 0", q.size());
         q.delete();
      end
   endtask

   task automatic idle_chk(input string nm);
      @(negedge clk);
      check({nm, "_busy"}, busy, 0);
      check({nm, "_valid"}, ser_valid, 0);
      check({nm, "_in_ready"}, in_ready, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic ls;
      tv[0] = '{8'hA5, 1'b1, 8'b10100101, 1'b0, 1'b0};
      tv[1] = '{8'h01, 1'b0, 8'b10000000, 1'b1, 1'b0};
      tv[2] = '{8'h07, 1'b1, 8'b00000111, 1'b1, 1'b0};
      tv[3] = '{8'h03, 1'b0, 8'b11000000, 1'b0, 1'b1};
      tv[4] = '{8'hC4, 1'b0, 8'b00100011, 1'b1, 1'b1};
      tv[5] = '{8'hF0, 1'b1, 8'b11110000, 1'b0, 1'b1};
      tv[6] = '{8'h0F, 1'b1, 8'b00001111, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      msb_first = 1'b0;
      ser_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", ser_valid, 0);
      check("rst_out", ser_out, 0);
      check("rst_last", ser_last, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_chk("reset");

      foreach (tv[i]) begin
         send(tv[i].d, tv[i].msb, tv[i].seq, tv[i].par, ls);
         drain(tv[i].stall);
         idle_chk("vec");
      end

      // Stall on bit 0 for three cycles.
      send(8'h01, 1'b0, 8'b10000000, 1'b1, ls);
      ser_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("stall_valid", ser_valid, 1);
         check("stall_out", ser_out, 1);
         check("stall_last", ser_last, 0);
      end
      @(posedge clk);
      #1;
      ser_ready = 1'b1;
      drain(1'b0);
      idle_chk("stall");

      // Back-to-back frames must stream without a bubble.
      max_run = 0;
      send(8'hF0, 1'b1, 8'b11110000, 1'b0, ls);
      send(8'h0F, 1'b1, 8'b00001111, 1'b0, ls);
      check("b2b_accept_on_last", ls, 1);
      drain(1'b0);
      check("b2b_run", max_run, 2 * FL);
      idle_chk("b2b");

      // Upstream traffic mid-frame must be refused.
      send(8'h00, 1'b1, 8'b00000000, 1'b0, ls);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         in_valid = (i % 2 == 0);
         in_data  = 8'hFF;
         @(negedge clk);
         check("ignore_in_ready", in_ready, 0);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      drain(1'b0);
      idle_chk("ignore");

      // Reset mid-frame drops the frame at once.
      send(8'hA5, 1'b1, 8'b10100101, 1'b0, ls);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_valid", ser_valid, 0);
      check("midrst_busy", busy, 0);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_chk("midrst");
      send(8'h03, 1'b0, 8'b11000000, 1'b0, ls);
      drain(1'b0);
      idle_chk("recover");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
